// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Read-side bus of the UART receiver: FIFO head, occupancy,
//               flow control and sticky error flags, plus the consumer's
//               pop / clear-error requests.
//   slave  modport : the receiver (drives rdata/rvalid/count/rts/flags)
//   master modport : the consumer (drives pop/clr_err)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    logic                     pop;
    logic                     clr_err;
    logic [DATA_W-1:0]        rdata;
    logic                     rvalid;
    logic [$clog2(DEPTH):0]   count;
    logic                     rts;
    logic                     frame_err;
    logic                     parity_err;
    logic                     overrun;

    modport slave (
        input  pop, clr_err,
        output rdata, rvalid, count, rts, frame_err, parity_err, overrun
    );

    modport master (
        output pop, clr_err,
        input  rdata, rvalid, count, rts, frame_err, parity_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Oversampling UART receiver feeding a first-word-fall-through
//               receive FIFO with RTS flow control and sticky error flags.
// Ports       : clk        - sole clock, rising edge
//               nReset     - synchronous reset, ACTIVE HIGH despite its name
//               rx         - asynchronous serial input, idle high
//               baud_div   - clk cycles per oversample tick (0 acts as 1)
//               parity_en  - frame carries a parity bit
//               parity_odd - parity sense (0 even, 1 odd)
//               two_stop   - frame carries two stop bits
//               bus        - read-side bus (pop, clr_err, rdata, rvalid,
//                            count, rts, frame_err, parity_err, overrun)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int OVS        = 16,
    parameter int DIV_W      = 16,
    parameter int RTS_THRESH = DEPTH - 2
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             rx,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop,
    uart_rx_fifo_if.slave    bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_OVS_W = $clog2(OVS);
    localparam int c_BIT_W = $clog2(DATA_W);

    localparam logic [c_OVS_W-1:0] c_OVS_LAST = c_OVS_W'(OVS - 1);
    localparam logic [c_OVS_W-1:0] c_OVS_MID  = c_OVS_W'(OVS / 2 - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_RTS_LVL  = c_CNT_W'(RTS_THRESH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to the idle level so reset never looks
    // like a start bit)
    // ------------------------------------------------------------------
    logic r_rxMeta;
    logic r_rxSync;

    always_ff @(posedge clk) begin
        if (nReset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick: down-counter reloaded from baud_div only when it
    // expires, so a divisor change never truncates the current period.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_divCnt;
    logic [DIV_W-1:0] w_divReload;
    logic             w_tick;

    assign w_tick      = (r_divCnt == '0);
    assign w_divReload = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);

    always_ff @(posedge clk) begin
        if (nReset) begin
            r_divCnt <= '0;
        end else if (w_tick) begin
            r_divCnt <= w_divReload;
        end else begin
            r_divCnt <= r_divCnt - DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t              r_state,     w_stateNext;
    logic [c_OVS_W-1:0]  r_ovsCnt,    w_ovsNext;
    logic [c_BIT_W-1:0]  r_bitCnt,    w_bitNext;
    logic [DATA_W-1:0]   r_shift,     w_shiftNext;
    logic                r_parBad,    w_parBadNext;
    logic                r_stopBad,   w_stopBadNext;
    logic                r_stopIdx,   w_stopIdxNext;
    logic                r_fmtParEn,  w_fmtParEnNext;
    logic                r_fmtParOdd, w_fmtParOddNext;
    logic                r_fmtTwo,    w_fmtTwoNext;
    logic                w_pushReq;
    logic                w_setFrameErr;
    logic                w_setParityErr;
    logic                w_stopBadNow;

    always_ff @(posedge clk) begin
        if (nReset) begin
            r_state     <= S_IDLE;
            r_ovsCnt    <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parBad    <= 1'b0;
            r_stopBad   <= 1'b0;
            r_stopIdx   <= 1'b0;
            r_fmtParEn  <= 1'b0;
            r_fmtParOdd <= 1'b0;
            r_fmtTwo    <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_ovsCnt    <= w_ovsNext;
            r_bitCnt    <= w_bitNext;
            r_shift     <= w_shiftNext;
            r_parBad    <= w_parBadNext;
            r_stopBad   <= w_stopBadNext;
            r_stopIdx   <= w_stopIdxNext;
            r_fmtParEn  <= w_fmtParEnNext;
            r_fmtParOdd <= w_fmtParOddNext;
            r_fmtTwo    <= w_fmtTwoNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_ovsNext        = r_ovsCnt;
        w_bitNext        = r_bitCnt;
        w_shiftNext      = r_shift;
        w_parBadNext     = r_parBad;
        w_stopBadNext    = r_stopBad;
        w_stopIdxNext    = r_stopIdx;
        w_fmtParEnNext   = r_fmtParEn;
        w_fmtParOddNext  = r_fmtParOdd;
        w_fmtTwoNext     = r_fmtTwo;
        w_pushReq        = 1'b0;
        w_setFrameErr    = 1'b0;
        w_setParityErr   = 1'b0;
        w_stopBadNow     = r_stopBad | ~r_rxSync;

        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxSync) begin
                        w_stateNext     = S_START;
                        w_ovsNext       = '0;
                        // Frame format is frozen for the whole frame here
                        w_fmtParEnNext  = parity_en;
                        w_fmtParOddNext = parity_odd;
                        w_fmtTwoNext    = two_stop;
                    end
                end

                S_START: begin
                    if (r_ovsCnt == c_OVS_MID) begin
                        w_ovsNext = '0;
                        if (!r_rxSync) begin
                            w_stateNext   = S_DATA;
                            w_bitNext     = '0;
                            w_parBadNext  = 1'b0;
                            w_stopBadNext = 1'b0;
                            w_stopIdxNext = 1'b0;
                        end else begin
                            // Glitch shorter than half a bit: quietly ignore
                            w_stateNext = S_IDLE;
                        end
                    end else begin
                        w_ovsNext = r_ovsCnt + c_OVS_W'(1);
                    end
                end

                S_DATA: begin
                    if (r_ovsCnt == c_OVS_LAST) begin
                        w_ovsNext   = '0;
                        // LSB arrives first, so shift in from the top
                        w_shiftNext = {r_rxSync, r_shift[DATA_W-1:1]};
                        if (r_bitCnt == c_BIT_LAST) begin
                            w_stateNext = r_fmtParEn ? S_PARITY : S_STOP;
                        end else begin
                            w_bitNext = r_bitCnt + c_BIT_W'(1);
                        end
                    end else begin
                        w_ovsNext = r_ovsCnt + c_OVS_W'(1);
                    end
                end

                S_PARITY: begin
                    if (r_ovsCnt == c_OVS_LAST) begin
                        w_ovsNext    = '0;
                        w_stateNext  = S_STOP;
                        w_parBadNext = (r_rxSync != ((^r_shift) ^ r_fmtParOdd));
                    end else begin
                        w_ovsNext = r_ovsCnt + c_OVS_W'(1);
                    end
                end

                S_STOP: begin
                    if (r_ovsCnt == c_OVS_LAST) begin
                        w_ovsNext = '0;
                        if (r_fmtTwo && !r_stopIdx) begin
                            w_stopIdxNext = 1'b1;
                            w_stopBadNext = w_stopBadNow;
                        end else begin
                            w_stateNext    = S_IDLE;
                            w_setFrameErr  = w_stopBadNow;
                            w_setParityErr = r_parBad;
                            w_pushReq      = ~w_stopBadNow & ~r_parBad;
                        end
                    end else begin
                        w_ovsNext = r_ovsCnt + c_OVS_W'(1);
                    end
                end

                default: begin
                    w_stateNext = S_IDLE;
                    w_ovsNext   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO (first word falls through onto rdata)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_countNext;
    logic               w_full;
    logic               w_empty;
    logic               w_doPush;
    logic               w_doPop;
    logic               r_rts;
    logic               r_frameErr;
    logic               r_parityErr;
    logic               r_overrun;

    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);
    assign w_doPop  = bus.pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_doPush = w_pushReq & (~w_full | w_doPop);

    assign w_countNext = r_count + {{(c_CNT_W-1){1'b0}}, w_doPush}
                                 - {{(c_CNT_W-1){1'b0}}, w_doPop};

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_rts       <= 1'b0;
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            r_count <= w_countNext;
            // Derived from next-state count so rts moves with count
            r_rts   <= (w_countNext >= c_RTS_LVL);
            // Set beats clear when both happen in one cycle
            r_frameErr  <= (r_frameErr  & ~bus.clr_err) | w_setFrameErr;
            r_parityErr <= (r_parityErr & ~bus.clr_err) | w_setParityErr;
            r_overrun   <= (r_overrun   & ~bus.clr_err) | (w_pushReq & ~w_doPush);
        end
    end

    assign bus.rdata      = w_empty ? '0 : r_mem[r_rdPtr];
    assign bus.rvalid     = ~w_empty;
    assign bus.count      = r_count;
    assign bus.rts        = r_rts;
    assign bus.frame_err  = r_frameErr;
    assign bus.parity_err = r_parityErr;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo: a table of frame
//               vectors, hand-written corner sequences, and a randomised run
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int OVS     = 16;
    localparam int DIV_W   = 16;
    localparam int RTS_LVL = DEPTH - 2;

    logic             clk        = 1'b0;
    logic             nReset     = 1'b1;
    logic             rx         = 1'b1;
    logic [DIV_W-1:0] baud_div   = 16'd1;
    logic             parity_en  = 1'b0;
    logic             parity_odd = 1'b0;
    logic             two_stop   = 1'b0;

    int nChecks = 0;
    int nErrors = 0;

    uart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .OVS(OVS), .DIV_W(DIV_W), .RTS_THRESH(RTS_LVL)
    ) dut (
        .clk(clk), .nReset(nReset), .rx(rx), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe, po, ts, parBit, stop1, stop2;
        logic       expPush, expFe, expPe;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int bitCycles();
        return OVS * ((baud_div == '0) ? 1 : int'(baud_div));
    endfunction

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * bitCycles()) @(negedge clk);
    endtask

    task automatic pulsePop();
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    task automatic pulseClr();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    // Drives one complete frame; earlyCount is the occupancy a quarter of
    // the way into the first stop bit, before the frame may be accepted.
    task automatic sendFrame(input logic [7:0] d, input logic pe, input logic po,
                             input logic ts, input logic parBit, input logic stop1,
                             input logic stop2, input logic scramble,
                             output int earlyCount);
        int bc;
        bc = bitCycles();
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        rx = 1'b0;
        repeat (bc / 2) @(negedge clk);
        if (scramble) begin
            parity_en  = 1'($urandom);
            parity_odd = 1'($urandom);
            two_stop   = 1'($urandom);
        end
        repeat (bc - bc / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bc) @(negedge clk);
        end
        if (pe) begin
            rx = parBit;
            repeat (bc) @(negedge clk);
        end
        rx = stop1;
        repeat (bc / 4) @(negedge clk);
        earlyCount = int'(bus.count);
        repeat (bc - bc / 4) @(negedge clk);
        if (ts) begin
            rx = stop2;
            repeat (bc) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " rvalid"},     bus.rvalid,     0);
        check({tag, " count"},      bus.count,      0);
        check({tag, " rdata"},      bus.rdata,      0);
        check({tag, " rts"},        bus.rts,        0);
        check({tag, " frame_err"},  bus.frame_err,  0);
        check({tag, " parity_err"}, bus.parity_err, 0);
        check({tag, " overrun"},    bus.overrun,    0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         early;
        logic [7:0] q [$];
        logic       mFe, mPe, mOv;

        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;

        //            d      pe    po    ts    par   st1   st2   push  fe    pe
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        nReset = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");
        idleBits(1);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 8; i++) begin
            sendFrame(vecs[i].d, vecs[i].pe, vecs[i].po, vecs[i].ts, vecs[i].parBit,
                      vecs[i].stop1, vecs[i].stop2, 1'b0, early);
            idleBits(2);
            check($sformatf("vec%0d early count", i), early, 0);
            check($sformatf("vec%0d count", i), bus.count, vecs[i].expPush);
            check($sformatf("vec%0d rvalid", i), bus.rvalid, vecs[i].expPush);
            check($sformatf("vec%0d rdata", i), bus.rdata,
                  vecs[i].expPush ? int'(vecs[i].d) : 0);
            check($sformatf("vec%0d frame_err", i), bus.frame_err, vecs[i].expFe);
            check($sformatf("vec%0d parity_err", i), bus.parity_err, vecs[i].expPe);
            check($sformatf("vec%0d overrun", i), bus.overrun, 0);
            if (vecs[i].expPush) begin
                pulsePop();
                check($sformatf("vec%0d rvalid after pop", i), bus.rvalid, 0);
            end
            pulseClr();
            check($sformatf("vec%0d frame_err cleared", i), bus.frame_err, 0);
            check($sformatf("vec%0d parity_err cleared", i), bus.parity_err, 0);
        end

        // ---------------- false start ----------------
        rx = 1'b0;
        repeat (6) @(negedge clk);
        idleBits(2);
        check("false start count", bus.count, 0);
        check("false start frame_err", bus.frame_err, 0);
        check("false start parity_err", bus.parity_err, 0);
        sendFrame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, early);
        idleBits(1);
        check("after false start rdata", bus.rdata, 8'h5A);
        check("after false start count", bus.count, 1);
        pulsePop();
        pulsePop();
        check("pop on empty count", bus.count, 0);

        // ---------------- fill, rts and overrun ----------------
        for (int i = 1; i <= 9; i++) begin
            sendFrame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, early);
            idleBits(1);
            check($sformatf("fill%0d count", i), bus.count, (i > DEPTH) ? DEPTH : i);
            check($sformatf("fill%0d rts", i), bus.rts, (i >= RTS_LVL) ? 1 : 0);
            check($sformatf("fill%0d overrun", i), bus.overrun, (i > DEPTH) ? 1 : 0);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            check($sformatf("drain%0d rdata", i), bus.rdata, i);
            pulsePop();
        end
        check("drained rvalid", bus.rvalid, 0);
        check("drained rts", bus.rts, 0);
        pulseClr();
        check("overrun cleared", bus.overrun, 0);

        // ---------------- reset in the middle of a frame ----------------
        sendFrame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, early);
        idleBits(2);
        sendFrame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, early);
        idleBits(2);
        check("pre-reset count", bus.count, 1);
        check("pre-reset frame_err", bus.frame_err, 1);
        rx = 1'b0;
        repeat (bitCycles()) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'($urandom);
            repeat (bitCycles()) @(negedge clk);
        end
        nReset = 1'b1;
        rx     = 1'b1;
        @(negedge clk);
        checkResetOutputs("midframe reset");
        nReset = 1'b0;
        idleBits(2);
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, early);
        idleBits(1);
        check("post-reset rdata", bus.rdata, 8'h3C);
        check("post-reset count", bus.count, 1);
        check("post-reset frame_err", bus.frame_err, 0);
        pulsePop();

        // ---------------- randomised run against the reference model ----------------
        mFe = 1'b0;
        mPe = 1'b0;
        mOv = 1'b0;
        for (int f = 0; f < 30; f++) begin
            logic [7:0] d;
            logic       pe, po, ts, parBit, st1, st2, stopBad, parBad;
            int         kind, nPop;
            baud_div = DIV_W'($urandom_range(0, 3));
            idleBits(1);
            d    = 8'($urandom);
            pe   = 1'($urandom);
            po   = 1'($urandom);
            ts   = 1'($urandom);
            kind = $urandom_range(0, 9);
            parBit = (^d) ^ po ^ (kind <= 1);
            st1    = (kind != 2);
            st2    = (kind != 3);
            sendFrame(d, pe, po, ts, parBit, st1, st2, 1'b1, early);
            idleBits(2);

            stopBad = !st1 || (ts && !st2);
            parBad  = pe && (parBit != ((^d) ^ po));
            if (stopBad) mFe = 1'b1;
            if (parBad)  mPe = 1'b1;
            if (!stopBad && !parBad) begin
                if (q.size() < DEPTH) q.push_back(d);
                else mOv = 1'b1;
            end

            check($sformatf("rnd%0d count", f), bus.count, q.size());
            check($sformatf("rnd%0d rdata", f), bus.rdata, (q.size() != 0) ? int'(q[0]) : 0);
            check($sformatf("rnd%0d rts", f), bus.rts, (q.size() >= RTS_LVL) ? 1 : 0);
            check($sformatf("rnd%0d flags", f),
                  {bus.frame_err, bus.parity_err, bus.overrun}, {mFe, mPe, mOv});

            nPop = $urandom_range(0, 2);
            for (int k = 0; k < nPop; k++) begin
                pulsePop();
                if (q.size() != 0) void'(q.pop_front());
            end
            if ($urandom_range(0, 3) == 0) begin
                pulseClr();
                mFe = 1'b0;
                mPe = 1'b0;
                mOv = 1'b0;
            end
            check($sformatf("rnd%0d count after pops", f), bus.count, q.size());
            check($sformatf("rnd%0d rdata after pops", f), bus.rdata,
                  (q.size() != 0) ? int'(q[0]) : 0);
            check($sformatf("rnd%0d flags after clr", f),
                  {bus.frame_err, bus.parity_err, bus.overrun}, {mFe, mPe, mOv});
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
`default_nettype wire
